// File: rtl/conv_result_writer.sv
// conv_result_writer: serialises 192-bit six-lane result buses into 32-bit external RAM writes,
// one frame of FRAME_BUSES buses per enable, with back-to-back bus acceptance and overflow flagging.
`default_nettype none

module conv_result_writer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_BUSES = 36
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  i_pixel_valid,
  input  logic [191:0]          i_pixel_bus,
  output logic                  o_ready,
  output logic [ADDR_WIDTH-1:0] ext_ram_addr,
  output logic [31:0]           ext_ram_data,
  output logic                  ext_ram_we,
  output logic                  o_done,
  output logic                  o_overflow
);

  localparam int BW = $clog2(FRAME_BUSES + 1);
  localparam logic [BW-1:0]         LAST_BUS = BW'(FRAME_BUSES - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, WAIT_BUS, WRITE, DONE} state_t;

  state_t                state, state_nxt;
  logic [2:0]            idx, idx_nxt;
  logic [BW-1:0]         bus_cnt, bus_cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr_cnt, addr_cnt_nxt;
  logic [191:0]          hold, hold_nxt;
  logic [31:0]           lane_word;
  logic                  lane_last;
  logic                  accept;

  assign lane_last = (idx == 3'd5);
  // Ready during the last lane of a non-final bus lets the next bus follow with no gap cycle.
  assign o_ready   = (state == WAIT_BUS) ||
                     ((state == WRITE) && lane_last && (bus_cnt < LAST_BUS));
  assign accept    = i_pixel_valid & o_ready;

  always_comb begin
    lane_word = hold[31:0];
    case (idx)
      3'd0:    lane_word = hold[191:160];
      3'd1:    lane_word = hold[159:128];
      3'd2:    lane_word = hold[127:96];
      3'd3:    lane_word = hold[95:64];
      3'd4:    lane_word = hold[63:32];
      default: lane_word = hold[31:0];
    endcase
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    bus_cnt_nxt  = bus_cnt;
    addr_cnt_nxt = addr_cnt;
    hold_nxt     = hold;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt    = WAIT_BUS;
          addr_cnt_nxt = BASE;
          bus_cnt_nxt  = '0;
          idx_nxt      = 3'd0;
        end
      end
      WAIT_BUS: begin
        if (accept) begin
          hold_nxt  = i_pixel_bus;
          idx_nxt   = 3'd0;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        addr_cnt_nxt = addr_cnt + 1'b1;
        if (lane_last) begin
          bus_cnt_nxt = bus_cnt + 1'b1;
          idx_nxt     = 3'd0;
          if (accept) begin
            hold_nxt = i_pixel_bus;
          end else if (bus_cnt == LAST_BUS) begin
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT_BUS;
          end
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      bus_cnt      <= '0;
      addr_cnt     <= '0;
      hold         <= '0;
      ext_ram_we   <= 1'b0;
      ext_ram_addr <= '0;
      ext_ram_data <= '0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      bus_cnt    <= bus_cnt_nxt;
      addr_cnt   <= addr_cnt_nxt;
      hold       <= hold_nxt;
      ext_ram_we <= (state == WRITE);
      o_done     <= (state == DONE);
      if (state == WRITE) begin
        ext_ram_addr <= addr_cnt;
        ext_ram_data <= lane_word;
      end
      if ((state == IDLE) && enable) begin
        o_overflow <= 1'b0;
      end else if ((state != IDLE) && i_pixel_valid && !o_ready) begin
        o_overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_result_writer.sv
// tb_conv_result_writer: directed self-checking bench for conv_result_writer (default frame and a
// small wrapping frame instance).
`default_nettype none

module tb_conv_result_writer;

  localparam logic [191:0] BUS_A = {32'h11111111, 32'h22222222, 32'h33333333,
                                    32'h44444444, 32'h55555555, 32'h66666666};
  localparam logic [191:0] BUS_B = {32'hB0000000, 32'hB1111111, 32'hB2222222,
                                    32'hB3333333, 32'hB4444444, 32'hB5555555};
  localparam logic [191:0] BUS_C = {32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2,
                                    32'hC3C3C3C3, 32'hC4C4C4C4, 32'hC5C5C5C5};
  localparam logic [191:0] BUS_E = {32'hAAAA0000, 32'hAAAA0001, 32'hAAAA0002,
                                    32'hAAAA0003, 32'hAAAA0004, 32'hAAAA0005};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, enable, valid;
  logic [191:0] bus;
  logic         ready, we, done, ovf;
  logic [7:0]   addr;
  logic [31:0]  data;

  logic         enable2, valid2;
  logic [191:0] bus2;
  logic         ready2, we2, done2, ovf2;
  logic [7:0]   addr2;
  logic [31:0]  data2;

  conv_result_writer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .i_pixel_valid(valid), .i_pixel_bus(bus),
    .o_ready(ready), .ext_ram_addr(addr), .ext_ram_data(data), .ext_ram_we(we),
    .o_done(done), .o_overflow(ovf)
  );

  conv_result_writer #(.ADDR_WIDTH(8), .BASE_ADDR(250), .FRAME_BUSES(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable2), .i_pixel_valid(valid2), .i_pixel_bus(bus2),
    .o_ready(ready2), .ext_ram_addr(addr2), .ext_ram_data(data2), .ext_ram_we(we2),
    .o_done(done2), .o_overflow(ovf2)
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int          dc[$];
  logic [7:0]  wa2[$];
  int          dc2[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      wa.push_back(addr);
      wd.push_back(data);
      wc.push_back(cyc);
    end
    if (done)  dc.push_back(cyc);
    if (we2)   wa2.push_back(addr2);
    if (done2) dc2.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane(input logic [191:0] b, input int i);
    return b[191-32*i -: 32];
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q();
    wa.delete(); wd.delete(); wc.delete(); dc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; valid = 1'b0;
    step();
    rst_n = 1'b1;
    clear_q();
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int k = 0;
    while (wa.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, 64'(wa.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (dc.size() == 0 && k < budget) begin
      step();
      k++;
    end
    check(tag, 64'(dc.size()), 64'd1);
  endtask

  initial begin
    int c;
    int bad_addr, bad_data, bad_gap;

    rst_n = 1'b0; enable = 1'b0; valid = 1'b0; bus = BUS_A;
    enable2 = 1'b0; valid2 = 1'b0; bus2 = BUS_C;

    // Reset with valid toggling.
    for (int i = 0; i < 2; i++) begin
      valid = ~valid;
      step();
    end
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_we",    64'(we),    64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_ovf",   64'(ovf),   64'd0);
    check("rst_addr",  64'(addr),  64'd0);
    check("rst_data",  64'(data),  64'd0);
    valid = 1'b0;

    // Single bus.
    rst_n = 1'b1;
    clear_q();
    step();
    check("idle_ready", 64'(ready), 64'd0);
    enable = 1'b1;
    step();
    check("wait_ready", 64'(ready), 64'd1);
    enable = 1'b0; valid = 1'b1; bus = BUS_A; c = cyc;
    step();
    valid = 1'b0;
    wait_writes("single_writes", 6, 20);
    check("single_ready_after", 64'(ready), 64'd1);
    check("single_first_cyc", 64'(wc[0]), 64'(c + 2));
    check("single_last_cyc",  64'(wc[5]), 64'(c + 7));
    for (int i = 0; i < 6; i++) begin
      check($sformatf("single_addr%0d", i), 64'(wa[i]), 64'(i));
      check($sformatf("single_data%0d", i), 64'(wd[i]), 64'(lane(BUS_A, i)));
    end

    // Overflow while writing lane 2, then complete the frame.
    do_reset();
    enable = 1'b1;
    step();
    enable = 1'b0; valid = 1'b1; bus = BUS_A; c = cyc;
    step();
    valid = 1'b0;
    step();
    step();
    check("ovf_ready_idx2", 64'(ready), 64'd0);
    check("ovf_before", 64'(ovf), 64'd0);
    valid = 1'b1; bus = BUS_B;
    step();
    valid = 1'b0;
    check("ovf_set", 64'(ovf), 64'd1);
    repeat (5) step();
    check("ovf_write_count", 64'(wa.size()), 64'd6);
    check("ovf_data0", 64'(wd[0]), 64'(lane(BUS_A, 0)));
    check("ovf_data5", 64'(wd[5]), 64'(lane(BUS_A, 5)));
    check("ovf_sticky", 64'(ovf), 64'd1);
    valid = 1'b1; bus = BUS_B;
    wait_done("ovf_frame_done", 400);
    valid = 1'b0;
    check("ovf_frame_words", 64'(wa.size()), 64'd216);
    check("ovf_still_set", 64'(ovf), 64'd1);
    step();
    enable = 1'b1;
    step();
    enable = 1'b0;
    check("ovf_cleared", 64'(ovf), 64'd0);

    // Full frame with valid held high.
    do_reset();
    enable = 1'b1; valid = 1'b1; bus = BUS_C;
    step();
    enable = 1'b0;
    wait_done("ff_done", 400);
    valid = 1'b0;
    check("ff_words", 64'(wa.size()), 64'd216);
    bad_addr = 0; bad_data = 0; bad_gap = 0;
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] !== 8'(i)) bad_addr++;
      if (wd[i] !== lane(BUS_C, i % 6)) bad_data++;
      if (wc[i] != wc[0] + i) bad_gap++;
    end
    check("ff_addr_seq", 64'(bad_addr), 64'd0);
    check("ff_data_seq", 64'(bad_data), 64'd0);
    check("ff_no_gaps",  64'(bad_gap),  64'd0);
    check("ff_last_addr", 64'(wa[wa.size()-1]), 64'd215);
    check("ff_done_cyc", 64'(dc[0]), 64'(wc[wc.size()-1] + 1));
    repeat (3) step();
    check("ff_done_once", 64'(dc.size()), 64'd1);
    check("ff_idle_ready", 64'(ready), 64'd0);

    // Reset during bus 3 lane 4.
    do_reset();
    enable = 1'b1; valid = 1'b1; bus = BUS_B;
    step();
    enable = 1'b0;
    wait_writes("mid_reach", 23, 100);
    check("mid_lane4_data", 64'(wd[22]), 64'(lane(BUS_B, 4)));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; valid = 1'b0;
    check("mid_we_off", 64'(we), 64'd0);
    check("mid_ready_off", 64'(ready), 64'd0);
    repeat (10) step();
    check("mid_no_done", 64'(dc.size()), 64'd0);
    check("mid_no_more_writes", 64'(wa.size()), 64'd23);
    clear_q();
    enable = 1'b1;
    step();
    enable = 1'b0; valid = 1'b1; bus = BUS_E;
    step();
    valid = 1'b0;
    wait_writes("mid_restart", 1, 20);
    check("mid_restart_addr", 64'(wa[0]), 64'd0);
    check("mid_restart_data", 64'(wd[0]), 64'(lane(BUS_E, 0)));

    // Address wrap on the small instance.
    enable2 = 1'b1; valid2 = 1'b1;
    step();
    enable2 = 1'b0;
    for (int k = 0; k < 40 && dc2.size() == 0; k++) step();
    valid2 = 1'b0;
    check("wrap_done", 64'(dc2.size()), 64'd1);
    check("wrap_words", 64'(wa2.size()), 64'd12);
    bad_addr = 0;
    for (int i = 0; i < wa2.size(); i++) begin
      if (wa2[i] !== 8'((250 + i) % 256)) bad_addr++;
    end
    check("wrap_addr_seq", 64'(bad_addr), 64'd0);
    check("wrap_addr5",  64'(wa2[5]), 64'd255);
    check("wrap_addr6",  64'(wa2[6]), 64'd0);
    check("wrap_addr11", 64'(wa2[11]), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
